// File: rtl/xadc_drp_scheduler.sv
// Round-robin DRP read sequencer for XADC aux channels: one read per end-of-conversion
// over the enabled channels, capturing the 12-bit result per channel and flagging DRP timeouts.
module xadc_drp_scheduler #(
  parameter int                NCH      = 4,
  parameter logic [NCH*7-1:0]  CH_ADDRS = {7'h16, 7'h1F, 7'h17, 7'h1E},
  parameter int                TIMEOUT  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_ch_en,
  input  logic              i_eoc,
  output logic              o_drp_den,
  output logic [6:0]        o_drp_daddr,
  output logic              o_drp_dwe,
  input  logic              i_drp_drdy,
  input  logic [15:0]       i_drp_do,
  output logic [NCH*12-1:0] o_result,
  output logic [NCH-1:0]    o_result_valid,
  output logic              o_sample_stb,
  output logic [2:0]        o_sample_ch,
  output logic              o_timeout_err
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                r_state, w_next;
  logic [2:0]            r_ptr, r_sel, w_sel, w_ptr_nxt;
  logic [TW-1:0]         r_timer;
  logic [6:0]            r_daddr;
  logic [NCH-1:0][11:0]  r_result;
  logic [NCH-1:0]        r_valid;
  logic                  r_stb, r_tout;
  logic [2:0]            r_sample_ch;
  logic                  w_start, w_done, w_tout, w_found;

  // First enabled channel at or after the round-robin pointer, wrapping.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && i_ch_en[PW'((int'(r_ptr) + k) % NCH)]) begin
        w_sel   = 3'((int'(r_ptr) + k) % NCH);
        w_found = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (r_sel == 3'(NCH - 1)) ? 3'd0 : r_sel + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_tout  = 1'b0;
    case (r_state)
      IDLE: if (i_eoc && |i_ch_en) begin
        w_start = 1'b1;
        w_next  = ISSUE;
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (i_drp_drdy) begin
          w_done = 1'b1;
          w_next = IDLE;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_tout = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_sel       <= '0;
      r_timer     <= '0;
      r_daddr     <= '0;
      r_result    <= '0;
      r_valid     <= '0;
      r_stb       <= 1'b0;
      r_tout      <= 1'b0;
      r_sample_ch <= '0;
    end else begin
      r_stb  <= 1'b0;
      r_tout <= 1'b0;
      if (w_start) begin
        r_sel   <= w_sel;
        r_daddr <= CH_ADDRS[7*int'(w_sel) +: 7];
      end
      if (r_state == ISSUE)     r_timer <= '0;
      else if (r_state == WAIT) r_timer <= r_timer + 1'b1;
      if (w_done || w_tout) r_ptr <= w_ptr_nxt;
      // A read that completes for a channel disabled meanwhile is dropped silently.
      if (w_done && i_ch_en[PW'(r_sel)]) begin
        r_result[PW'(r_sel)] <= i_drp_do[15:4];
        r_valid[PW'(r_sel)]  <= 1'b1;
        r_stb                <= 1'b1;
        r_sample_ch          <= r_sel;
      end
      if (w_tout) begin
        r_tout      <= 1'b1;
        r_sample_ch <= r_sel;
      end
      for (int i = 0; i < NCH; i++) begin
        if (!i_ch_en[i]) begin
          r_result[i] <= '0;
          r_valid[i]  <= 1'b0;
        end
      end
    end
  end

  assign o_drp_den      = (r_state == ISSUE);
  assign o_drp_daddr    = r_daddr;
  assign o_drp_dwe      = 1'b0;
  assign o_result       = r_result;
  assign o_result_valid = r_valid;
  assign o_sample_stb   = r_stb;
  assign o_sample_ch    = r_sample_ch;
  assign o_timeout_err  = r_tout;
endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: transaction-age reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_xadc_drp_scheduler;
  localparam int NCH = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst, eoc, drdy;
  logic [3:0]  en;
  logic [15:0] dout;
  logic        den, dwe, stb, terr;
  logic [6:0]  daddr;
  logic [47:0] res;
  logic [3:0]  val;
  logic [2:0]  sch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xadc_drp_scheduler #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_ch_en(en), .i_eoc(eoc),
    .o_drp_den(den), .o_drp_daddr(daddr), .o_drp_dwe(dwe),
    .i_drp_drdy(drdy), .i_drp_do(dout),
    .o_result(res), .o_result_valid(val), .o_sample_stb(stb),
    .o_sample_ch(sch), .o_timeout_err(terr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_age counts cycles since den (-1 = no read outstanding).
  logic [6:0]  addr_tab [NCH] = '{7'h1E, 7'h17, 7'h1F, 7'h16};
  int          m_age = -1, m_ptr = 0, m_ch = 0, m_sch = 0;
  logic        m_den = 0, m_stb = 0, m_terr = 0;
  logic [6:0]  m_daddr = 0;
  logic [11:0] m_res [NCH] = '{default: 0};
  logic        m_val [NCH] = '{default: 0};
  bit          chk_on = 0;
  int          den_cnt = 0, stb_cnt = 0, terr_cnt = 0;

  always @(negedge clk) begin
    logic [47:0] er;
    logic [3:0]  ev;
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) begin
        er[12*i +: 12] = m_res[i];
        ev[i]          = m_val[i];
      end
      chk("den", 64'(den), 64'(m_den));
      chk("daddr", 64'(daddr), 64'(m_daddr));
      chk("dwe", 64'(dwe), 64'(0));
      chk("result", 64'(res), 64'(er));
      chk("result_valid", 64'(val), 64'(ev));
      chk("sample_stb", 64'(stb), 64'(m_stb));
      chk("sample_ch", 64'(sch), 64'(m_sch));
      chk("timeout_err", 64'(terr), 64'(m_terr));
    end
    if (den)  den_cnt++;
    if (stb)  stb_cnt++;
    if (terr) terr_cnt++;
    // advance model with the inputs the next rising edge will sample
    if (rst) begin
      m_age = -1; m_ptr = 0; m_ch = 0; m_sch = 0;
      m_den = 0; m_stb = 0; m_terr = 0; m_daddr = 0;
      for (int i = 0; i < NCH; i++) begin m_res[i] = 0; m_val[i] = 0; end
    end else begin
      m_den = 0; m_stb = 0; m_terr = 0;
      if (m_age < 0) begin
        if (eoc && en != 0) begin
          for (int k = 0; k < NCH; k++)
            if (en[(m_ptr + k) % NCH]) begin m_ch = (m_ptr + k) % NCH; break; end
          m_daddr = addr_tab[m_ch];
          m_den   = 1;
          m_age   = 0;
        end
      end else if (m_age >= 1 && drdy) begin
        m_ptr = (m_ch + 1) % NCH;
        if (en[m_ch]) begin
          m_res[m_ch] = dout[15:4];
          m_val[m_ch] = 1;
          m_stb       = 1;
          m_sch       = m_ch;
        end
        m_age = -1;
      end else if (m_age == TIMEOUT) begin
        m_terr = 1;
        m_sch  = m_ch;
        m_ptr  = (m_ch + 1) % NCH;
        m_age  = -1;
      end else begin
        m_age++;
      end
      for (int i = 0; i < NCH; i++)
        if (!en[i]) begin m_res[i] = 0; m_val[i] = 0; end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // eoc pulse, then drdy dly cycles after den; returns the address presented with den
  task automatic do_read(input int dly, input logic [15:0] d, output logic [6:0] addr);
    eoc = 1; tick; eoc = 0;
    chk("den_seen", 64'(den), 64'(1));
    addr = daddr;
    repeat (dly) tick;
    drdy = 1; dout = d; tick; drdy = 0;
  endtask

  initial begin
    logic [6:0] a;
    logic [6:0] exp_a [4] = '{7'h1E, 7'h16, 7'h1E, 7'h16};
    logic [2:0] exp_c [4] = '{3'd0, 3'd3, 3'd0, 3'd3};
    int c0, t0;
    rst = 1; eoc = 0; drdy = 0; en = 0; dout = 0;
    repeat (3) tick;
    chk_on = 1;
    chk("reset_den", 64'(den), 64'(0));
    chk("reset_result", 64'(res), 64'(0));
    rst = 0; tick;

    // round robin over channels 0 and 3
    en = 4'b1001; tick;
    for (int i = 0; i < 4; i++) begin
      do_read(3, 16'(i * 16'h1110 + 16'h0105), a);
      chk("rr_addr", 64'(a), 64'(exp_a[i]));
      chk("rr_ch", 64'(sch), 64'(exp_c[i]));
      tick;
    end

    // single channel capture, den one cycle wide
    en = 4'b0010; tick;
    c0 = stb_cnt;
    eoc = 1; tick; eoc = 0;
    chk("den_hi", 64'(den), 64'(1));
    tick;
    chk("den_lo", 64'(den), 64'(0));
    tick; drdy = 1; dout = 16'hABCD; tick; drdy = 0;
    chk("cap_result", 64'(res[23:12]), 64'(12'hABC));
    chk("cap_valid", 64'(val), 64'(4'b0010));
    tick;
    chk("cap_one_stb", 64'(stb_cnt - c0), 64'(1));

    // timeout on channel 2, then pointer moves on to channel 1
    en = 4'b0110; tick;
    eoc = 1; tick; eoc = 0;
    chk("to_addr", 64'(daddr), 64'(7'h1F));
    t0 = 0;
    while (!terr && t0 < 100) begin tick; t0++; end
    chk("to_seen", 64'(terr), 64'(1));
    chk("to_result", 64'(res), 64'(48'h000000ABC000));
    chk("to_valid", 64'(val), 64'(4'b0010));
    tick;
    do_read(2, 16'h1230, a);
    chk("to_next_addr", 64'(a), 64'(7'h17));
    tick;

    // eoc during WAIT is dropped
    en = 4'b1111; tick;
    eoc = 1; tick;
    c0 = den_cnt;
    tick; tick; eoc = 0;
    drdy = 1; dout = 16'h5550; tick; drdy = 0;
    repeat (3) tick;
    chk("drop_den_cnt", 64'(den_cnt - c0), 64'(1));
    do_read(1, 16'h7770, a);
    chk("drop_next_addr", 64'(a), 64'(7'h16));
    tick;

    // disable channel while its read is in flight
    en = 4'b0100; tick;
    eoc = 1; tick; eoc = 0;
    chk("dis_addr", 64'(daddr), 64'(7'h1F));
    tick; en = 4'b0000; tick;
    drdy = 1; dout = 16'hFFF0; tick; drdy = 0; tick;
    chk("dis_result", 64'(res[35:24]), 64'(0));
    chk("dis_valid", 64'(val[2]), 64'(0));

    // reset mid-read, late drdy ignored
    en = 4'b1111; tick;
    eoc = 1; tick; eoc = 0; tick;
    rst = 1; tick; rst = 0;
    drdy = 1; dout = 16'hFFFF; tick; drdy = 0; tick;
    chk("rst_result", 64'(res), 64'(0));
    chk("rst_valid", 64'(val), 64'(0));
    chk("rst_ch", 64'(sch), 64'(0));
    do_read(2, 16'h4440, a);
    chk("rst_first_addr", 64'(a), 64'(7'h1E));
    tick;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) en = 4'($urandom);
      eoc  = ($urandom_range(3) == 0);
      drdy = ($urandom_range(4) == 0);
      dout = 16'($urandom);
      rst  = ($urandom_range(299) == 0);
      tick;
    end
    rst = 0; eoc = 0; drdy = 0;
    repeat (4) tick;
    chk("saw_timeouts", 64'(terr_cnt > 0), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
